// File: rtl/rd_arbiter.sv
// rtl/rd_arbiter.sv - round-robin burst arbiter for the shared FIFO read port
// Grants one consumer at a time; pops are same-cycle, grants and owner registered.
module rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BURST_MAX  = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         rdy,
  input  logic                       empty,
  output logic                       rd_inc,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rd_vld,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [BW-1:0]   burst_cnt;
  logic [SW-1:0]   starve_cnt;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   idx;
  logic            found;
  logic            owner_req;
  logic            pop;
  logic            release_now;

  // Search starts just past the previous owner so a re-requester queues behind others.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(last) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign owner_req = (state == GRANT) && req[owner_id];
  assign pop       = owner_req && rdy[owner_id] && !empty;
  assign rd_inc    = pop;
  assign rd_vld    = gnt & {NUM_REQ{pop}};

  assign release_now = (pop && (burst_cnt == BW'(BURST_MAX - 1)))
                    || !owner_req
                    || (empty && (starve_cnt == SW'(STARVE_MAX - 1)));

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state      <= IDLE;
      gnt        <= '0;
      owner_id   <= '0;
      busy       <= 1'b0;
      burst_cnt  <= '0;
      starve_cnt <= '0;
      last       <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= GRANT;
            busy       <= 1'b1;
            gnt        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            owner_id   <= sel;
            last       <= sel;
            burst_cnt  <= '0;
            starve_cnt <= '0;
          end
        end
        GRANT: begin
          // Stalled owner with data present leaves both counters untouched.
          if (pop) begin
            burst_cnt  <= burst_cnt + 1'b1;
            starve_cnt <= '0;
          end else if (owner_req && empty && (starve_cnt != SW'(STARVE_MAX - 1))) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
          if (release_now) begin
            state <= IDLE;
            busy  <= 1'b0;
            gnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule
